// File: rtl/nch_half_pwm_burst.sv
// nch_half_pwm_burst: CHANNELS independent complementary half-bridge PWM
// engines. Each engine runs A_ON -> DEAD_AB -> B_ON -> DEAD_BA for a
// programmable number of periods (0 = run until aborted). The A/B pair is
// never driven to the active level together.
module nch_half_pwm_burst #(
  parameter int _RAM_WIDTH = 32,
  parameter int CHANNELS   = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                             io_clk,
  input  logic                             io_rst,
  input  logic [CHANNELS-1:0]              io_en,
  input  logic [CHANNELS-1:0]              pwm_dis,
  input  logic [CHANNELS-1:0]              io_defaultLevel,
  input  logic [CHANNELS*_RAM_WIDTH-1:0]   pulse_period,
  input  logic [CHANNELS*_RAM_WIDTH-1:0]   die_period,
  input  logic [CHANNELS*CNT_WIDTH-1:0]    pulse_num,
  output logic [CHANNELS-1:0]              io_pulseOut_a,
  output logic [CHANNELS-1:0]              io_pulseOut_b,
  output logic [CHANNELS-1:0]              busy,
  output logic [CHANNELS-1:0]              pulse_valid
);

  localparam logic [_RAM_WIDTH-1:0] PH_ONE  = _RAM_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE = CNT_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_A_ON,
    S_DEAD_AB,
    S_B_ON,
    S_DEAD_BA
  } state_e;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    // Live configuration slice for this channel
    logic [_RAM_WIDTH-1:0] cfg_on;
    logic [_RAM_WIDTH-1:0] cfg_dead;
    logic [CNT_WIDTH-1:0]  cfg_num;

    // Burst state and configuration captured at start
    state_e                state_q;
    logic [_RAM_WIDTH-1:0] phase_q;
    logic [_RAM_WIDTH-1:0] on_last_q;
    logic [_RAM_WIDTH-1:0] dead_last_q;
    logic                  dead_skip_q;
    logic [CNT_WIDTH-1:0]  per_cnt_q;
    logic [CNT_WIDTH-1:0]  per_num_q;
    logic                  lvl_q;
    logic                  a_q;
    logic                  b_q;
    logic                  busy_q;
    logic                  valid_q;

    // Phase/period decode
    logic                  on_done;
    logic                  dead_done;
    logic                  period_end;
    logic                  last_period;
    logic [CNT_WIDTH-1:0]  per_cnt_inc;

    assign cfg_on   = pulse_period[gi*_RAM_WIDTH +: _RAM_WIDTH];
    assign cfg_dead = die_period[gi*_RAM_WIDTH +: _RAM_WIDTH];
    assign cfg_num  = pulse_num[gi*CNT_WIDTH +: CNT_WIDTH];

    // Terminal-count compares run at full width, so no counter wrap occurs
    assign on_done     = (phase_q == on_last_q);
    assign dead_done   = (phase_q == dead_last_q);
    assign per_cnt_inc = per_cnt_q + CNT_ONE;
    assign last_period = (per_num_q != '0) && (per_cnt_inc == per_num_q);

    // A full A+B period ends either at the end of DEAD_BA, or at the end of
    // B_ON when dead time is zero and the DEAD states are skipped
    assign period_end = ((state_q == S_B_ON) && on_done && dead_skip_q) ||
                        ((state_q == S_DEAD_BA) && dead_done);

    // Channel FSM with registered outputs; abort and reset take priority
    always_ff @(posedge io_clk) begin
      if (io_rst) begin
        state_q     <= S_IDLE;
        phase_q     <= '0;
        per_cnt_q   <= '0;
        on_last_q   <= '0;
        dead_last_q <= '0;
        dead_skip_q <= 1'b0;
        per_num_q   <= '0;
        lvl_q       <= 1'b0;
        busy_q      <= 1'b0;
        valid_q     <= 1'b0;
        a_q         <= io_defaultLevel[gi];
        b_q         <= io_defaultLevel[gi];
      end else if (pwm_dis[gi]) begin
        state_q   <= S_IDLE;
        phase_q   <= '0;
        per_cnt_q <= '0;
        busy_q    <= 1'b0;
        valid_q   <= 1'b0;
        a_q       <= io_defaultLevel[gi];
        b_q       <= io_defaultLevel[gi];
      end else begin
        valid_q <= 1'b0;
        unique case (state_q)
          S_IDLE: begin
            // Idle outputs track the live inactive level
            a_q    <= io_defaultLevel[gi];
            b_q    <= io_defaultLevel[gi];
            busy_q <= 1'b0;
            if (io_en[gi]) begin
              // An on-time of 0 behaves as 1
              on_last_q   <= (cfg_on == '0) ? '0 : (cfg_on - PH_ONE);
              dead_last_q <= cfg_dead - PH_ONE;
              dead_skip_q <= (cfg_dead == '0);
              per_num_q   <= cfg_num;
              lvl_q       <= io_defaultLevel[gi];
              state_q     <= S_A_ON;
              phase_q     <= '0;
              per_cnt_q   <= '0;
              busy_q      <= 1'b1;
              a_q         <= ~io_defaultLevel[gi];
              b_q         <= io_defaultLevel[gi];
            end
          end
          S_A_ON: begin
            if (on_done) begin
              phase_q <= '0;
              if (dead_skip_q) begin
                state_q <= S_B_ON;
                a_q     <= lvl_q;
                b_q     <= ~lvl_q;
              end else begin
                state_q <= S_DEAD_AB;
                a_q     <= lvl_q;
                b_q     <= lvl_q;
              end
            end else begin
              phase_q <= phase_q + PH_ONE;
            end
          end
          S_DEAD_AB: begin
            if (dead_done) begin
              phase_q <= '0;
              state_q <= S_B_ON;
              a_q     <= lvl_q;
              b_q     <= ~lvl_q;
            end else begin
              phase_q <= phase_q + PH_ONE;
            end
          end
          S_B_ON: begin
            // With zero dead time the period-end block below takes over
            if (on_done) begin
              phase_q <= '0;
              if (!dead_skip_q) begin
                state_q <= S_DEAD_BA;
                a_q     <= lvl_q;
                b_q     <= lvl_q;
              end
            end else begin
              phase_q <= phase_q + PH_ONE;
            end
          end
          S_DEAD_BA: begin
            if (dead_done) begin
              phase_q <= '0;
            end else begin
              phase_q <= phase_q + PH_ONE;
            end
          end
          default: begin
            state_q <= S_IDLE;
            phase_q <= '0;
            busy_q  <= 1'b0;
            a_q     <= io_defaultLevel[gi];
            b_q     <= io_defaultLevel[gi];
          end
        endcase

        // Period boundary: either finish the burst or start the next A phase.
        // In continuous mode the period counter simply wraps.
        if (period_end) begin
          per_cnt_q <= per_cnt_inc;
          if (last_period) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            valid_q <= 1'b1;
            a_q     <= io_defaultLevel[gi];
            b_q     <= io_defaultLevel[gi];
          end else begin
            state_q <= S_A_ON;
            a_q     <= ~lvl_q;
            b_q     <= lvl_q;
          end
        end
      end
    end

    assign io_pulseOut_a[gi] = a_q;
    assign io_pulseOut_b[gi] = b_q;
    assign busy[gi]          = busy_q;
    assign pulse_valid[gi]   = valid_q;
  end

endmodule

// File: tb/tb_nch_half_pwm_burst.sv
// Directed bench for nch_half_pwm_burst. Expected per-cycle outputs come from
// the closed-form timing windows of each burst and are queued one cycle ahead.
module tb_nch_half_pwm_burst;
  localparam int W   = 32;
  localparam int CH  = 4;
  localparam int C   = 16;
  localparam int INF = 32'h7fff_ffff;

  logic            clk = 1'b0;
  logic            rst;
  logic [CH-1:0]   en, dis, lvl_in;
  logic [CH*W-1:0] pp, dp;
  logic [CH*C-1:0] pn;
  logic [CH-1:0]   out_a, out_b, busy_o, valid_o;

  always #5 clk = ~clk;

  nch_half_pwm_burst #(._RAM_WIDTH(W), .CHANNELS(CH), .CNT_WIDTH(C)) dut (
    .io_clk(clk), .io_rst(rst), .io_en(en), .pwm_dis(dis),
    .io_defaultLevel(lvl_in), .pulse_period(pp), .die_period(dp),
    .pulse_num(pn), .io_pulseOut_a(out_a), .io_pulseOut_b(out_b),
    .busy(busy_o), .pulse_valid(valid_o)
  );

  typedef struct {
    int          cyc;
    logic [CH-1:0] a, b, bz, v, inact;
  } exp_t;
  exp_t q[$];

  int   errors = 0;
  int   checks = 0;
  int   cur    = 0;
  bit   act   [CH];
  int   n_s   [CH];
  int   p_s   [CH];
  int   d_s   [CH];
  int   k_s   [CH];
  int   stop_s[CH];
  logic lvl_s [CH];

  // Expected outputs of channel ch in cycle t (start sampled in cycle n_s)
  function automatic void model(input int ch, input int t, input logic live,
                                output logic a, output logic b, output logic bz,
                                output logic v, output logic inact);
    int per, off, pos, p, d;
    a = live; b = live; bz = 1'b0; v = 1'b0; inact = live;
    if (!act[ch] || t > stop_s[ch]) return;
    p = p_s[ch]; d = d_s[ch];
    per = 2 * p + 2 * d;
    off = t - n_s[ch] - 1;
    if (off < 0) return;
    if (k_s[ch] != 0 && off >= k_s[ch] * per) begin
      v = (off == k_s[ch] * per);
      return;
    end
    pos   = off % per;
    bz    = 1'b1;
    inact = lvl_s[ch];
    a     = (pos < p) ? ~lvl_s[ch] : lvl_s[ch];
    b     = (pos >= p + d && pos < 2 * p + d) ? ~lvl_s[ch] : lvl_s[ch];
  endfunction

  task automatic set_cfg(input int ch, input int p, input int d, input int k);
    pp[ch*W +: W] = W'(p);
    dp[ch*W +: W] = W'(d);
    pn[ch*C +: C] = C'(k);
  endtask

  // One clock: resolve start/abort, queue next-cycle expectation, compare
  task automatic tick();
    logic a, b, bz, v, ia;
    exp_t e;
    for (int ch = 0; ch < CH; ch++) begin
      model(ch, cur, lvl_in[ch], a, b, bz, v, ia);
      if (rst || dis[ch]) begin
        if (stop_s[ch] > cur) stop_s[ch] = cur;
      end else if (en[ch] && !bz) begin
        act[ch]    = 1'b1;
        n_s[ch]    = cur;
        p_s[ch]    = (pp[ch*W +: W] == 0) ? 1 : int'(pp[ch*W +: W]);
        d_s[ch]    = int'(dp[ch*W +: W]);
        k_s[ch]    = int'(pn[ch*C +: C]);
        lvl_s[ch]  = lvl_in[ch];
        stop_s[ch] = INF;
      end
    end
    e.cyc = cur + 1;
    for (int ch = 0; ch < CH; ch++) begin
      model(ch, cur + 1, lvl_in[ch], a, b, bz, v, ia);
      e.a[ch] = a; e.b[ch] = b; e.bz[ch] = bz; e.v[ch] = v; e.inact[ch] = ia;
    end
    q.push_back(e);
    @(posedge clk);
    #1;
    cur++;
    en  = '0;
    dis = '0;
    rst = 1'b0;
    e = q.pop_front();
    for (int ch = 0; ch < CH; ch++) begin
      checks++;
      assert ({out_a[ch], out_b[ch], busy_o[ch], valid_o[ch]} ===
              {e.a[ch], e.b[ch], e.bz[ch], e.v[ch]})
      else begin
        errors++;
        $error("FAIL abv ch%0d cyc%0d a/b/busy/valid got %b%b%b%b expected %b%b%b%b",
               ch, e.cyc, out_a[ch], out_b[ch], busy_o[ch], valid_o[ch],
               e.a[ch], e.b[ch], e.bz[ch], e.v[ch]);
      end
      checks++;
      assert (out_a[ch] === e.inact[ch] || out_b[ch] === e.inact[ch])
      else begin
        errors++;
        $error("FAIL overlap ch%0d cyc%0d a=%b b=%b inactive level required %b",
               ch, e.cyc, out_a[ch], out_b[ch], e.inact[ch]);
      end
    end
  endtask

  initial begin
    rst = 1'b1; en = '0; dis = '0; lvl_in = 4'b0010;
    pp = '0; dp = '0; pn = '0;
    for (int ch = 0; ch < CH; ch++) begin
      act[ch] = 1'b0; stop_s[ch] = INF; n_s[ch] = 0;
      p_s[ch] = 1; d_s[ch] = 0; k_s[ch] = 0; lvl_s[ch] = 1'b0;
    end
    // Reset
    tick();
    rst = 1'b1; tick();

    // Burst ch0 P=5 D=3 K=2, ignored re-strobe at 10, restart at valid cycle
    set_cfg(0, 5, 3, 2); en[0] = 1'b1; tick();
    repeat (9) tick();
    en[0] = 1'b1; tick();
    repeat (22) tick();
    en[0] = 1'b1; tick();
    set_cfg(0, 2, 1, 1);              // mid-burst change must not matter
    repeat (34) tick();

    // ch1 zero dead time, inverted level
    set_cfg(1, 4, 0, 1); en[1] = 1'b1; tick();
    repeat (12) tick();

    // ch2 continuous, abort at 40, then simultaneous start+abort
    set_cfg(2, 5, 3, 0); en[2] = 1'b1; tick();
    repeat (39) tick();
    dis[2] = 1'b1; tick();
    repeat (5) tick();
    en[2] = 1'b1; dis[2] = 1'b1; tick();
    repeat (4) tick();

    // All channels staggered with different P/D/K (ch2 has P=0)
    set_cfg(0, 3, 1, 2); en[0] = 1'b1; tick();
    set_cfg(1, 2, 0, 3); en[1] = 1'b1; tick();
    set_cfg(2, 0, 2, 1); en[2] = 1'b1; tick();
    set_cfg(3, 4, 2, 0); en[3] = 1'b1; tick();
    repeat (36) tick();
    dis[3] = 1'b1; tick();
    repeat (3) tick();

    // Reset mid-burst at cycle 7
    set_cfg(0, 5, 3, 2); en[0] = 1'b1; tick();
    repeat (6) tick();
    rst = 1'b1; tick();
    repeat (5) tick();

    // Idle outputs follow the live level
    lvl_in = 4'b1001;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
